// File: rtl/serial_ineq_sequencer.sv
// rtl/serial_ineq_sequencer.sv - bit-serial inequality comparator with start/busy/done handshake
// Optional macro SERIAL_INEQ_EARLY_EXIT_EN: finish the scan on the first differing bit.
module serial_ineq_sequencer #(
  parameter int WIDTH = 5,
  localparam int IDXW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             not_equal,
  output logic [IDXW-1:0]  diff_idx
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [IDXW-1:0]  r_idx;
  logic             r_busy;
  logic             r_done;
  logic             r_not_equal;
  logic [IDXW-1:0]  r_diff_idx;

  logic w_bit_diff;
  logic w_last;

  // The single shared comparator: one XOR on the currently selected bit pair.
  assign w_bit_diff = r_op_a[r_idx] ^ r_op_b[r_idx];

`ifdef SERIAL_INEQ_EARLY_EXIT_EN
  assign w_last = (r_idx == LAST_IDX) | (w_bit_diff & ~r_not_equal);
`else
  assign w_last = (r_idx == LAST_IDX);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_idx       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_not_equal <= 1'b0;
      r_diff_idx  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_op_a      <= a;
            r_op_b      <= b;
            r_idx       <= '0;
            r_not_equal <= 1'b0;
            r_diff_idx  <= '0;
            r_busy      <= 1'b1;
            r_state     <= S_SCAN;
          end
        end
        S_SCAN: begin
          // not_equal doubles as the mismatch flag, so only the lowest index sticks.
          if (w_bit_diff && !r_not_equal) begin
            r_not_equal <= 1'b1;
            r_diff_idx  <= r_idx;
          end
          if (w_last) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign not_equal = r_not_equal;
  assign diff_idx  = r_diff_idx;

endmodule

// File: tb/tb_serial_ineq_sequencer.sv
// tb/tb_serial_ineq_sequencer.sv - self-checking bench for serial_ineq_sequencer (WIDTH=5)
module tb_serial_ineq_sequencer;

  localparam int WIDTH = 5;
  localparam int IDXW = $clog2(WIDTH);

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             not_equal;
  logic [IDXW-1:0]  diff_idx;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 0;

  serial_ineq_sequencer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .not_equal(not_equal), .diff_idx(diff_idx)
  );

  initial clk = 0;
  always #5 clk = ~clk;

`ifdef SERIAL_INEQ_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  // Transaction-level model: on acceptance, compute the final answer and how many
  // edges the operation lasts, then count those edges down.
  bit m_busy, m_done, m_ne;
  int m_idx, m_left, m_fin_ne, m_fin_idx;

  function automatic void model_eval(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                     output int ne, output int idx, output int lat);
    logic [WIDTH-1:0] d;
    d = x ^ y;
    ne = (d != 0);
    idx = 0;
    for (int i = WIDTH - 1; i >= 0; i--) if (d[i]) idx = i;
    lat = (EARLY && ne) ? idx + 1 : WIDTH;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_ne = 0; m_idx = 0; m_left = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 0; m_done = 1; m_ne = m_fin_ne[0]; m_idx = m_fin_idx;
      end
    end else if (start) begin
      model_eval(a, b, m_fin_ne, m_fin_idx, m_left);
      m_busy = 1; m_ne = 0; m_idx = 0;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_busy", int'(busy), int'(m_busy));
      check("model_done", int'(done), int'(m_done));
      if (!busy) begin
        check("model_ne", int'(not_equal), int'(m_ne));
        check("model_idx", int'(diff_idx), m_idx);
      end
    end
  end

  // Drive one operation; 'hold' keeps start high afterwards. Returns edges after accept.
  task automatic run_op(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                        input bit hold, output int lat);
    @(negedge clk);
    a = va; b = vb; start = 1;
    @(negedge clk);
    if (!hold) start = 0;
    lat = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!done) check("done_timeout", 0, 1);
  endtask

  task automatic op_check(input string name, input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                          input int exp_ne, input int exp_idx, input int lat_full, input int lat_early);
    int lat;
    run_op(va, vb, 0, lat);
    check({name, "_lat"}, lat, EARLY ? lat_early : lat_full);
    check({name, "_ne"}, int'(not_equal), exp_ne);
    check({name, "_idx"}, int'(diff_idx), exp_idx);
    check({name, "_busy_at_done"}, int'(busy), 0);
  endtask

  initial begin
    int lat;
    rst_n = 0; start = 0; a = '0; b = '0;
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    cmp_en = 1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_ne", int'(not_equal), 0);
    check("rst_idx", int'(diff_idx), 0);
    repeat (3) @(negedge clk);
    check("idle_busy", int'(busy), 0);

    op_check("equal", 5'b10101, 5'b10101, 0, 0, 5, 5);
    op_check("multi", 5'b11111, 5'b00001, 1, 1, 5, 2);
    op_check("lsb",   5'b11100, 5'b11101, 1, 0, 5, 1);
    op_check("msb",   5'b00000, 5'b10000, 1, 4, 5, 5);

    // Busy protection: operand changes during SCAN are ignored; held start re-accepted.
    @(negedge clk);
    a = 5'b01110; b = 5'b01110; start = 1;
    @(negedge clk);
    a = 5'b11111; b = 5'b00000;
    lat = 0;
    while (!done && lat < 20) begin @(negedge clk); lat++; end
    check("prot_lat", lat, 5);
    check("prot_ne", int'(not_equal), 0);
    @(negedge clk);
    check("prot_idle_busy", int'(busy), 0);
    @(negedge clk);
    check("prot_reaccept_busy", int'(busy), 1);
    start = 0;
    lat = 0;
    while (!done && lat < 20) begin @(negedge clk); lat++; end
    check("prot2_lat", lat, EARLY ? 1 : 5);
    check("prot2_ne", int'(not_equal), 1);
    check("prot2_idx", int'(diff_idx), 0);

    // Reset during SCAN discards the operation without a done pulse.
    @(negedge clk);
    a = 5'b11111; b = 5'b00001; start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_ne", int'(not_equal), 0);
    check("mid_rst_idx", int'(diff_idx), 0);
    rst_n = 1;
    repeat (6) begin
      @(negedge clk);
      check("mid_rst_no_done", int'(done), 0);
    end
    op_check("after_rst", 5'b01000, 5'b00000, 1, 3, 5, 4);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
